// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer
//   Circular receive buffer sitting between the UART receiver and the core's
//   in/fin datapath. Each rising edge of rx_valid captures one byte. Reads are
//   request/acknowledge and deliver either a single byte or a word of
//   BYTES_PER_WORD bytes, assembled big- or little-endian.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   rx_data/valid   byte and valid level from the receiver
//   rd_req/rd_mode  read request level (sampled in IDLE); 0 = byte, 1 = word
//   flush           drop everything buffered (honoured only in IDLE)
//   rd_ack/rd_data  one-cycle acknowledge with the assembled data
//   byte_count      bytes stored and not yet reserved by a read
//   empty/full      byte_count == 0 / byte_count == DEPTH
//   overflow        sticky: a byte arrived while full and was dropped
module uart_rx_buffer #(
  parameter int DEPTH          = 4096,
  parameter int BYTES_PER_WORD = 4,
  parameter bit BIG_ENDIAN     = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  input  logic                     rd_req,
  input  logic                     rd_mode,
  input  logic                     flush,
  output logic                     rd_ack,
  output logic [31:0]              rd_data,
  output logic [$clog2(DEPTH):0]   byte_count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, FETCH, ACK} state_t;

  state_t            state, state_d;
  logic [7:0]        mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr, start_q;
  logic [CW-1:0]     count;
  logic              rx_valid_q;
  logic [2:0]        n_q, k_q, n_req;
  logic [7:0]        mem_q;
  logic [3:0][7:0]   asm_q, asm_d;

  logic capture, full_i, cap_ok, accept, do_flush, fetch_last;

  assign capture    = rx_valid & ~rx_valid_q;
  assign full_i     = (count == CW'(DEPTH));
  assign cap_ok     = capture & ~full_i;
  assign n_req      = rd_mode ? 3'(BYTES_PER_WORD) : 3'd1;
  assign do_flush   = (state == IDLE) && flush;
  assign accept     = (state == IDLE) && !flush && rd_req && (count >= CW'(n_req));
  // k_q counts FETCH cycles: k < N issues a read, k >= 1 places byte k-1,
  // so the last byte lands when k == N.
  assign fetch_last = (state == FETCH) && (k_q == n_q);

  assign byte_count = count;
  assign empty      = (count == '0);
  assign full       = full_i;
  assign rd_ack     = (state == ACK);

  // ---------------- read FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept)     state_d = FETCH;
      FETCH:   if (fetch_last) state_d = ACK;
      ACK:                     state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // ---------------- write side ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid_q <= 1'b0;
      wr_ptr     <= '0;
      overflow   <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      if (cap_ok)            wr_ptr   <= wr_ptr + 1'b1;
      if (capture && full_i) overflow <= 1'b1;
    end
  end

  // Storage kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (cap_ok) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (state == FETCH && k_q < n_q) mem_q <= mem[start_q + AW'(k_q)];
  end

  // ---------------- byte placement ----------------
  always_comb begin
    logic [2:0] idx, pos;
    asm_d = asm_q;
    idx   = k_q - 3'd1;
    pos   = BIG_ENDIAN ? (n_q - 3'd1 - idx) : idx;
    if (k_q != 3'd0) begin
      for (int b = 0; b < 4; b++)
        if (pos == 3'(b)) asm_d[b] = mem_q;
    end
  end

  // ---------------- pointers, count, assembly ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      count   <= '0;
      start_q <= '0;
      n_q     <= 3'd0;
      k_q     <= 3'd0;
      asm_q   <= '0;
      rd_data <= '0;
    end else begin
      if (do_flush) begin
        // A byte captured in the flush cycle lands at wr_ptr and survives.
        rd_ptr <= wr_ptr;
        count  <= CW'(cap_ok);
      end else begin
        count <= count + CW'(cap_ok) - (accept ? CW'(n_req) : CW'(0));
        if (accept) begin
          rd_ptr  <= rd_ptr + AW'(n_req);
          start_q <= rd_ptr;
          n_q     <= n_req;
          k_q     <= 3'd0;
          asm_q   <= '0;
        end
      end
      if (state == FETCH) begin
        k_q   <= k_q + 3'd1;
        asm_q <= asm_d;
        if (fetch_last) rd_data <= asm_d;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_buffer.sv
module tb_uart_rx_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data [3];
  logic        rx_valid[3], rd_req[3], rd_mode[3], flush[3];
  logic        rd_ack[3], empty[3], full[3], overflow[3];
  logic [31:0] rd_data[3];
  logic [12:0] bc0, bc1;
  logic [2:0]  bc2;
  int          vhold[3];
  int          vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  // 0: defaults, 1: little-endian, 2: DEPTH 4 with 3-byte words
  uart_rx_buffer u0 (.clk(clk), .rst(rst), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
    .rd_req(rd_req[0]), .rd_mode(rd_mode[0]), .flush(flush[0]), .rd_ack(rd_ack[0]),
    .rd_data(rd_data[0]), .byte_count(bc0), .empty(empty[0]), .full(full[0]),
    .overflow(overflow[0]));
  uart_rx_buffer #(.BIG_ENDIAN(1'b0)) u1 (.clk(clk), .rst(rst), .rx_data(rx_data[1]),
    .rx_valid(rx_valid[1]), .rd_req(rd_req[1]), .rd_mode(rd_mode[1]), .flush(flush[1]),
    .rd_ack(rd_ack[1]), .rd_data(rd_data[1]), .byte_count(bc1), .empty(empty[1]),
    .full(full[1]), .overflow(overflow[1]));
  uart_rx_buffer #(.DEPTH(4), .BYTES_PER_WORD(3)) u2 (.clk(clk), .rst(rst),
    .rx_data(rx_data[2]), .rx_valid(rx_valid[2]), .rd_req(rd_req[2]), .rd_mode(rd_mode[2]),
    .flush(flush[2]), .rd_ack(rd_ack[2]), .rd_data(rd_data[2]), .byte_count(bc2),
    .empty(empty[2]), .full(full[2]), .overflow(overflow[2]));

  function automatic logic [31:0] get_bc(int d);
    case (d)
      0:       return 32'(bc0);
      1:       return 32'(bc1);
      default: return 32'(bc2);
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++)
      if (vhold[d] > 0) begin
        vhold[d]--;
        if (vhold[d] == 0) rx_valid[d] = 1'b0;
      end
  endtask

  task automatic raise_valid(int d, logic [7:0] b);
    rx_data[d]  = b;
    rx_valid[d] = 1'b1;
    vhold[d]    = 3;
  endtask

  task automatic send_byte(int d, logic [7:0] b);
    raise_valid(d, b);
    repeat (4) tick();
  endtask

  task automatic no_ack(int d, int cycles, string tag);
    logic seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (rd_ack[d]) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  // called right after the acceptance edge; ack must appear n+1 edges later
  task automatic wait_ack(int d, int n, logic [31:0] exp, string tag);
    logic early = 1'b0;
    for (int i = 1; i <= n + 1; i++) begin
      tick();
      if (i <= n && rd_ack[d]) early = 1'b1;
    end
    chk({tag, "_early"}, 32'(early), 32'd0);
    chk({tag, "_ack"}, 32'(rd_ack[d]), 32'd1);
    chk({tag, "_data"}, rd_data[d], exp);
    tick();
    chk({tag, "_pulse"}, 32'(rd_ack[d]), 32'd0);
  endtask

  task automatic read_op(int d, logic mode, int n, logic cap, logic [7:0] cb,
                         logic [31:0] exp, string tag);
    int pre;
    pre = int'(get_bc(d));
    rd_req[d]  = 1'b1;
    rd_mode[d] = mode;
    if (cap) raise_valid(d, cb);
    tick();
    rd_req[d] = 1'b0;
    chk({tag, "_cnt"}, get_bc(d), 32'(pre + int'(cap) - n));
    wait_ack(d, n, exp, tag);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rx_data[d] = 8'h00; rx_valid[d] = 1'b0; rd_req[d] = 1'b0;
      rd_mode[d] = 1'b0;  flush[d] = 1'b0;    vhold[d] = 0;
    end
    repeat (2) tick();
    rst = 1'b0;

    chk("rst_ack",   32'(rd_ack[0]),   32'd0);
    chk("rst_data",  rd_data[0],       32'd0);
    chk("rst_count", get_bc(0),        32'd0);
    chk("rst_empty", 32'(empty[0]),    32'd1);
    chk("rst_full",  32'(full[0]),     32'd0);
    chk("rst_ovf",   32'(overflow[0]), 32'd0);

    // word assembly, both byte orders
    send_byte(0, 8'h12); send_byte(0, 8'h34); send_byte(0, 8'h56); send_byte(0, 8'h78);
    chk("be_count4", get_bc(0), 32'd4);
    read_op(0, 1'b1, 4, 1'b0, 8'h00, 32'h12345678, "be_word");
    chk("be_empty", 32'(empty[0]), 32'd1);
    send_byte(1, 8'h12); send_byte(1, 8'h34); send_byte(1, 8'h56); send_byte(1, 8'h78);
    read_op(1, 1'b1, 4, 1'b0, 8'h00, 32'h78563412, "le_word");

    // word request waits until the fourth byte arrives
    send_byte(0, 8'h11); send_byte(0, 8'h22);
    rd_req[0] = 1'b1; rd_mode[0] = 1'b1;
    no_ack(0, 8, "wait_noack");
    chk("wait_count2", get_bc(0), 32'd2);
    send_byte(0, 8'h33);
    chk("wait_count3", get_bc(0), 32'd3);
    raise_valid(0, 8'h44);
    tick();
    chk("wait_count4", get_bc(0), 32'd4);
    tick();
    rd_req[0] = 1'b0;
    chk("wait_accept", get_bc(0), 32'd0);
    wait_ack(0, 4, 32'h11223344, "wait_word");

    // byte mode
    send_byte(0, 8'hA5);
    read_op(0, 1'b0, 1, 1'b0, 8'h00, 32'h000000A5, "byte_a5");

    // capture on the acceptance edge
    send_byte(0, 8'h01);
    read_op(0, 1'b0, 1, 1'b1, 8'h02, 32'h00000001, "cap_acc");
    read_op(0, 1'b0, 1, 1'b0, 8'h00, 32'h00000002, "cap_acc2");

    // flush + request + capture in one IDLE cycle
    send_byte(0, 8'h77);
    flush[0] = 1'b1; rd_req[0] = 1'b1; rd_mode[0] = 1'b0;
    raise_valid(0, 8'h5A);
    tick();
    flush[0] = 1'b0; rd_req[0] = 1'b0;
    chk("flush_count", get_bc(0), 32'd1);
    no_ack(0, 4, "flush_noack");
    read_op(0, 1'b0, 1, 1'b0, 8'h00, 32'h0000005A, "flush_5a");

    // full and overflow on the 4-deep instance
    for (int i = 0; i < 5; i++) send_byte(2, 8'(8'hF0 + i));
    chk("full_full",  32'(full[2]),     32'd1);
    chk("full_ovf",   32'(overflow[2]), 32'd1);
    chk("full_count", get_bc(2),        32'd4);
    for (int i = 0; i < 4; i++)
      read_op(2, 1'b0, 1, 1'b0, 8'h00, 32'(8'hF0 + i), "full_rd");
    chk("full_ovf_sticky", 32'(overflow[2]), 32'd1);
    chk("full_cleared",    32'(full[2]),     32'd0);

    // 3-byte words straddling the pointer wrap
    send_byte(2, 8'hA0); send_byte(2, 8'hA1); send_byte(2, 8'hA2);
    read_op(2, 1'b1, 3, 1'b1, 8'hA3, 32'h00A0A1A2, "wrap0");
    send_byte(2, 8'hA4); send_byte(2, 8'hA5);
    read_op(2, 1'b1, 3, 1'b1, 8'hA6, 32'h00A3A4A5, "wrap1");
    send_byte(2, 8'hA7); send_byte(2, 8'hA8);
    read_op(2, 1'b1, 3, 1'b0, 8'h00, 32'h00A6A7A8, "wrap2");
    chk("wrap_count", get_bc(2), 32'd0);

    // reset in the middle of a fetch
    send_byte(0, 8'hC1);
    rd_req[0] = 1'b1; rd_mode[0] = 1'b0;
    tick();
    rd_req[0] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    no_ack(0, 4, "rstmid_noack");
    chk("rstmid_count", get_bc(0),       32'd0);
    chk("rstmid_empty", 32'(empty[0]),   32'd1);
    chk("rstmid_data",  rd_data[0],      32'd0);
    chk("rstmid_ovf2",  32'(overflow[2]), 32'd0);
    send_byte(0, 8'hD7);
    read_op(0, 1'b0, 1, 1'b0, 8'h00, 32'h000000D7, "rstmid_d7");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
